// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Holds the PC and issues word reads to instruction
//   memory over a req/gnt + rvalid handshake, with at most one read in flight.
//   Returned words are buffered in an in-order prefetch FIFO. The FIFO head is
//   presented to decode with its PC and opcode field. A redirect flushes the
//   FIFO, squashes any in-flight read and reloads the PC.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   imem_req/addr      read request and word address (addr = current PC)
//   imem_gnt           memory accepted the request this cycle
//   imem_rvalid/rdata  read data return
//   redirect_valid/pc  taken branch/jump and its target (low 2 bits ignored)
//   instr_valid/ready  head-of-FIFO handshake toward decode
//   instr, instr_pc    head instruction and its PC
//   op, op_illegal     head opcode field and its illegal flag
//
// FSM states
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   S_IDLE    | no read in flight; waiting for a free FIFO slot
//   S_REQ     | imem_req asserted at pc, waiting for gnt
//   S_WAIT    | read granted, waiting for rvalid; data will be pushed
//   S_DISCARD | read granted but squashed by a redirect; data will be dropped
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [5:0]        op,
    output logic              op_illegal
);

    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic [CNT_W-1:0]  count_q, count_d, count_after;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] last_instr_q;
    logic [ADDR_W-1:0] last_pc_q;

    logic [DATA_W-1:0] fifo_instr [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc    [FIFO_DEPTH];

    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] redirect_tgt;

    function automatic logic op_is_legal(input logic [5:0] o);
        return o inside {[6'd0:6'd5], [6'd10:6'd14], 6'd20, 6'd21, 6'd30, 6'd31};
    endfunction

    assign redirect_tgt = redirect_pc & ~ADDR_W'(3);

    // A redirect kills both the head pop and any data returning this cycle.
    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid && instr_ready && !redirect_valid;
    assign push        = (state_q == S_WAIT) && imem_rvalid && !redirect_valid;
    assign count_after = count_q + CNT_W'(push) - CNT_W'(pop);

    // When the FIFO is empty the outputs keep showing the last head.
    assign instr      = instr_valid ? fifo_instr[rd_ptr_q] : last_instr_q;
    assign instr_pc   = instr_valid ? fifo_pc[rd_ptr_q]    : last_pc_q;
    assign op         = instr[DATA_W-1 -: 6];
    assign op_illegal = instr_valid && !op_is_legal(op);
    assign imem_addr  = pc_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        imem_req = 1'b0;
        case (state_q)
            S_IDLE: begin
                // No read is in flight here, so a free slot now is a slot
                // for the next read's data.
                if (!redirect_valid && (count_q < DEPTH_C)) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    pc_d     = pc_q + ADDR_W'(4);
                    req_pc_d = pc_q;
                    state_d  = redirect_valid ? S_DISCARD : S_WAIT;
                end else if (redirect_valid) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = (!redirect_valid && (count_after < DEPTH_C)) ? S_REQ : S_IDLE;
                end else if (redirect_valid) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (imem_rvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (redirect_valid) begin
            pc_d = redirect_tgt;
        end
    end

    always_comb begin
        count_d  = count_after;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        if (redirect_valid) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            last_instr_q <= '0;
            last_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            last_instr_q <= instr;
            last_pc_q    <= instr_pc;
        end
    end

    // Storage needs no reset: it is only visible through the head while
    // count_q is non-zero, i.e. after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr_q] <= imem_rdata;
            fifo_pc[wr_ptr_q]    <= req_pc_q;
        end
    end

endmodule
